// File: rtl/prog_writer.sv
// nic8 instruction encoder: packs symbolic fields into opcode (+ immediate) bytes,
// queues them in a small FIFO and writes them into program memory from address 0.
module prog_writer #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_dest,
  input  logic [2:0]        in_source,
  input  logic              in_sub,
  input  logic              in_carry,
  input  logic [7:0]        in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              idle,
  output logic              overflow,
  output logic              illegal
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  READY_MAX = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [7:0]        fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic              overflow_q, overflow_d;
  logic              illegal_q, illegal_d;

  logic [7:0] opcode, enq0, enq1;
  logic [1:0] n_enq;
  logic       accept, push_op, push_imm, fifo_empty, pop, deq;

  always_comb begin
    opcode     = {in_carry, in_dest, in_sub, in_source};
    fifo_empty = (cnt_q == '0);
    in_ready   = !overflow_q && (cnt_q <= READY_MAX);
    accept     = in_valid && in_ready;
    push_op    = accept && (in_dest != 3'd7);
    push_imm   = push_op && (in_source == 3'd0);
    pop        = !overflow_q && (!fifo_empty || push_op);
    deq        = pop && !fifo_empty;
    idle       = fifo_empty && !mem_we_q;

    // With an empty FIFO the opcode goes straight to the write registers,
    // so only the immediate (if any) needs storing.
    if (fifo_empty) begin
      enq0  = in_imm;
      enq1  = in_imm;
      n_enq = {1'b0, push_imm};
    end else begin
      enq0  = opcode;
      enq1  = in_imm;
      n_enq = {push_imm, push_op && !push_imm};
    end

    fifo_d = fifo_q;
    if (n_enq != 2'd0) fifo_d[wr_q] = enq0;
    if (n_enq == 2'd2) fifo_d[wr_q + PTR_W'(1)] = enq1;
    wr_d  = wr_q + PTR_W'(n_enq);
    rd_d  = rd_q + PTR_W'(deq);
    cnt_d = cnt_q + CNT_W'(n_enq) - CNT_W'(deq);

    mem_we_d   = pop;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    waddr_d    = waddr_q;
    overflow_d = overflow_q;
    if (pop) begin
      mem_addr_d = waddr_q;
      mem_data_d = fifo_empty ? opcode : fifo_q[rd_q];
      // The pointer parks on the last address; overflow then blocks all traffic.
      if (waddr_q == LAST_ADDR) overflow_d = 1'b1;
      else                      waddr_d    = waddr_q + ADDR_W'(1);
    end

    illegal_d = illegal_q || (accept && (in_dest == 3'd7));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      waddr_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      waddr_q    <= waddr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
    end
  end

  // Storage contents are don't-care until written, so they carry no reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign overflow = overflow_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_prog_writer.sv
// Bench for prog_writer: directed vector table, corner sequences and a random
// stream checked against a byte-queue reference model.
module tb_prog_writer;
  localparam int D = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, in_ready, in_sub, in_carry;
  logic [2:0] in_dest, in_source;
  logic [7:0] in_imm, mem_addr, mem_data;
  logic       mem_we, idle, overflow, illegal;

  logic       s_reset, s_in_valid, s_in_ready, s_in_sub, s_in_carry;
  logic [2:0] s_in_dest, s_in_source;
  logic [7:0] s_in_imm, s_mem_data;
  logic [1:0] s_mem_addr;
  logic       s_mem_we, s_idle, s_overflow, s_illegal;

  prog_writer #(.ADDR_W(8), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_source(in_source), .in_sub(in_sub), .in_carry(in_carry),
    .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .idle(idle), .overflow(overflow), .illegal(illegal));

  prog_writer #(.ADDR_W(2), .FIFO_DEPTH(D)) dut_small (
    .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_dest(s_in_dest), .in_source(s_in_source), .in_sub(s_in_sub), .in_carry(s_in_carry),
    .in_imm(s_in_imm), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_data(s_mem_data),
    .idle(s_idle), .overflow(s_overflow), .illegal(s_illegal));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: bytes accepted but not yet seen on the memory port.
  byte unsigned exp_q[$];
  int           exp_addr = 0;
  bit           exp_ill  = 1'b0;
  bit           accepted = 1'b0;

  function automatic logic [7:0] enc(input int c, input int d, input int s, input int src);
    return 8'(c * 128 + d * 16 + s * 8 + src);
  endfunction

  initial forever begin
    @(posedge clk);
    accepted = 1'b0;
    if (reset) begin
      exp_q.delete();
      exp_addr = 0;
      exp_ill  = 1'b0;
    end else if (in_valid && in_ready) begin
      accepted = 1'b1;
      if (in_dest == 3'd7) exp_ill = 1'b1;
      else begin
        exp_q.push_back(enc(int'(in_carry), int'(in_dest), int'(in_sub), int'(in_source)));
        if (in_source == 3'd0) exp_q.push_back(in_imm);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_spurious_we: write at 0x%0h data 0x%0h with nothing pending", mem_addr, mem_data);
        end else begin
          chk("mon_data", mem_data, exp_q.pop_front());
          chk("mon_addr", mem_addr, exp_addr);
          exp_addr++;
        end
      end
      chk("mon_ready", in_ready, (exp_q.size() <= D - 2));
      chk("mon_illegal", illegal, exp_ill);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] dest;
    logic [2:0] src;
    logic       sub;
    logic       carry;
    logic [7:0] imm;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  vec_t tbl[7];

  task automatic drive(input logic [2:0] d, input logic [2:0] s, input logic sb,
                       input logic cy, input logic [7:0] im);
    in_dest = d; in_source = s; in_sub = sb; in_carry = cy; in_imm = im;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic stream(input int n, input bit force_imm, input int pct, input int bound,
                        output int lowcnt);
    int sent = 0;
    int cyc  = 0;
    lowcnt   = 0;
    in_valid = 1'b0;
    while (sent < n && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (accepted) sent++;
      if (sent >= n) break;
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(99) < pct);
        if (force_imm)
          drive(3'($urandom_range(6)), 3'd0, 1'($urandom), 1'($urandom), 8'($urandom));
        else
          drive(3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom), 1'($urandom), 8'($urandom));
      end
      if (!in_ready) lowcnt++;
    end
    in_valid = 1'b0;
    chk("stream_sent", sent, n);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (!(idle && exp_q.size() == 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_idle"}, idle, 1);
    chk({name, "_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int base, low, wcount;
    reset = 1'b1;
    in_valid = 1'b0;
    drive(3'd0, 3'd0, 1'b0, 1'b0, 8'h00);
    s_reset = 1'b1;
    s_in_valid = 1'b0;
    s_in_dest = 3'd2; s_in_source = 3'd1; s_in_sub = 1'b0; s_in_carry = 1'b0; s_in_imm = 8'h00;

    tbl[0] = '{3'd2, 3'd0, 1'b0, 1'b0, 8'h2A, 2, 8'h20, 8'h2A};
    tbl[1] = '{3'd3, 3'd2, 1'b1, 1'b0, 8'h00, 1, 8'h3A, 8'h00};
    tbl[2] = '{3'd5, 3'd4, 1'b0, 1'b0, 8'h77, 1, 8'h54, 8'h00};
    tbl[3] = '{3'd1, 3'd0, 1'b0, 1'b1, 8'h10, 2, 8'h90, 8'h10};
    tbl[4] = '{3'd4, 3'd7, 1'b1, 1'b1, 8'h00, 1, 8'hCF, 8'h00};
    tbl[5] = '{3'd6, 3'd5, 1'b0, 1'b0, 8'h00, 1, 8'h65, 8'h00};
    tbl[6] = '{3'd0, 3'd0, 1'b0, 1'b0, 8'hFF, 2, 8'h00, 8'hFF};

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_idle", idle, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    // single instructions from the table
    do_reset();
    base = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(tbl[i].dest, tbl[i].src, tbl[i].sub, tbl[i].carry, tbl[i].imm);
      in_valid = 1'b1;
      chk("tbl_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < tbl[i].n; k++) begin
        chk("tbl_we", mem_we, 1);
        chk("tbl_addr", mem_addr, base + k);
        chk("tbl_data", mem_data, (k == 0) ? tbl[i].b0 : tbl[i].b1);
        @(negedge clk);
      end
      chk("tbl_we_off", mem_we, 0);
      chk("tbl_idle", idle, 1);
      base += tbl[i].n;
    end

    // back-to-back one-byte instructions
    do_reset();
    @(negedge clk);
    drive(3'd3, 3'd2, 1'b1, 1'b0, 8'h00);
    in_valid = 1'b1;
    chk("b2b_ready0", in_ready, 1);
    @(negedge clk);
    chk("b2b_ready1", in_ready, 1);
    chk("b2b_we0", mem_we, 1);
    chk("b2b_addr0", mem_addr, 0);
    chk("b2b_data0", mem_data, 8'h3A);
    drive(3'd5, 3'd4, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_we1", mem_we, 1);
    chk("b2b_addr1", mem_addr, 1);
    chk("b2b_data1", mem_data, 8'h54);
    @(negedge clk);
    chk("b2b_we_off", mem_we, 0);

    // illegal destination
    do_reset();
    @(negedge clk);
    drive(3'd7, 3'd1, 1'b0, 1'b0, 8'h00);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_flag", illegal, 1);
    chk("ill_no_we", mem_we, 0);
    @(negedge clk);
    chk("ill_no_we2", mem_we, 0);
    drive(3'd2, 3'd1, 1'b0, 1'b0, 8'h00);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_next_we", mem_we, 1);
    chk("ill_next_addr", mem_addr, 0);
    chk("ill_next_data", mem_data, 8'h21);

    // reset with bytes still queued
    @(negedge clk);
    in_valid = 1'b1;
    drive(3'd2, 3'd0, 1'b0, 1'b0, 8'hAA);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("midrst_busy", idle, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_we", mem_we, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_data", mem_data, 0);
    chk("midrst_illegal", illegal, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_idle", idle, 1);
    reset = 1'b0;
    @(negedge clk);
    drive(3'd3, 3'd1, 1'b0, 1'b0, 8'h00);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst_new_we", mem_we, 1);
    chk("midrst_new_addr", mem_addr, 0);
    chk("midrst_new_data", mem_data, 8'h31);
    @(negedge clk);
    chk("midrst_after_we", mem_we, 0);
    chk("midrst_after_idle", idle, 1);

    // continuous instructions with immediates: backpressure must appear
    do_reset();
    stream(20, 1'b1, 100, 400, low);
    chk("imm_ready_dropped", (low > 0), 1);
    drain("imm_drain");
    chk("imm_bytes_written", exp_addr, 40);

    // random mix
    do_reset();
    stream(150, 1'b0, 70, 3000, low);
    drain("rnd_drain");

    // small address space: overflow after address 3
    @(negedge clk);
    s_reset = 1'b0;
    s_in_valid = 1'b1;
    wcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 5) s_in_valid = 1'b0;
      if (s_mem_we) begin
        chk("ovf_addr", s_mem_addr, wcount);
        chk("ovf_data", s_mem_data, 8'h21);
        wcount++;
      end
    end
    chk("ovf_write_count", wcount, 4);
    chk("ovf_flag", s_overflow, 1);
    chk("ovf_ready", s_in_ready, 0);
    s_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovf_no_we", s_mem_we, 0);
    chk("ovf_ready_held", s_in_ready, 0);
    s_in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
